// File: rtl/room_ctrl_pkg.sv
// ============================================================================
// room_ctrl_pkg : shared state encoding and command constants for room_ctrl_fsm
// Revision      : 1.0
// ============================================================================
`default_nettype none

package room_ctrl_pkg;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic FUNC_LIGHT = 1'b1;
  localparam logic FUNC_DOOR  = 1'b0;
  localparam logic ON         = 1'b1;
  localparam logic OFF        = 1'b0;

endpackage

`default_nettype wire

// File: rtl/room_state_bank.sv
// ============================================================================
// room_state_bank : per-room light/door bits with one indexed write port
// Revision        : 1.0
// ============================================================================
`default_nettype none

module room_state_bank
  import room_ctrl_pkg::*;
#(
  parameter int NUM_ROOMS = 10,
  parameter int ROOM_W    = $clog2(NUM_ROOMS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ROOM_W-1:0]    wr_room,
  input  logic                 wr_func,
  input  logic                 wr_val,
  input  logic                 zero_all,
  output logic [NUM_ROOMS-1:0] light_state,
  output logic [NUM_ROOMS-1:0] door_state
);

  logic [NUM_ROOMS-1:0] light_q, light_d;
  logic [NUM_ROOMS-1:0] door_q,  door_d;

  // Compare against every legal index so out-of-range wr_room values write nothing
  always_comb begin
    light_d = light_q;
    door_d  = door_q;
    if (zero_all) begin
      light_d = '0;
      door_d  = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_ROOMS; i++) begin
        if (wr_room == ROOM_W'(i)) begin
          if (wr_func == FUNC_LIGHT) light_d[i] = wr_val;
          else                       door_d[i]  = wr_val;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      light_q <= '0;
      door_q  <= '0;
    end else begin
      light_q <= light_d;
      door_q  <= door_d;
    end
  end

  assign light_state = light_q;
  assign door_state  = door_q;

endmodule

`default_nettype wire

// File: rtl/room_ctrl_fsm.sv
// ============================================================================
// room_ctrl_fsm : load/clear command sequencer driving a VGA draw datapath
// Revision      : 1.0
// ============================================================================
`default_nettype none

module room_ctrl_fsm
  import room_ctrl_pkg::*;
#(
  parameter int NUM_ROOMS = 10,
  parameter int ROOM_W    = $clog2(NUM_ROOMS),
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_btn,
  input  logic                 func_in,
  input  logic                 onoff_in,
  input  logic [NUM_ROOMS-1:0] room_sel,
  input  logic                 clear_req,
  input  logic                 draw_done,
  output logic [NUM_ROOMS-1:0] light_state,
  output logic [NUM_ROOMS-1:0] door_state,
  output logic                 draw_en,
  output logic                 clear_en,
  output logic [ROOM_W-1:0]    cmd_room,
  output logic                 cmd_func,
  output logic                 cmd_onoff,
  output logic                 aud_valid,
  output logic                 done,
  output logic                 err
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [ROOM_W-1:0] room_q, room_d, low_idx;
  logic              func_q, func_d, onoff_q, onoff_d;
  logic              aud_q, aud_d, done_q, done_d, err_q, err_d;
  logic              release_w, cmd_ok, cmd_bad, busy, expired, zero_all;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
      if (room_sel[i]) low_idx = ROOM_W'(i);
    end
  end

  assign release_w = (state_q == S_WAIT) && !load_btn;
  assign cmd_ok    = release_w && (room_sel != '0);
  assign cmd_bad   = release_w && (room_sel == '0);
  assign busy      = (state_q == S_DRAW) || (state_q == S_CLEAR);
  assign expired   = busy && !draw_done && (wd_q == WD_LAST);
  assign zero_all  = (state_q == S_IDLE) && (state_d == S_CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_CLEAR;
      wd_q    <= '0;
      room_q  <= '0;
      func_q  <= 1'b0;
      onoff_q <= 1'b0;
      aud_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      room_q  <= room_d;
      func_q  <= func_d;
      onoff_q <= onoff_d;
      aud_q   <= aud_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_btn)       state_d = S_WAIT;
        else if (clear_req) state_d = S_CLEAR;
      end
      S_WAIT: begin
        if (!load_btn) state_d = (room_sel != '0) ? S_DRAW : S_IDLE;
      end
      S_DRAW, S_CLEAR: begin
        if (draw_done)            state_d = S_DONE;
        else if (wd_q == WD_LAST) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  // Watchdog restarts on every entry to a busy state and saturates instead of wrapping
  always_comb begin
    wd_d = '0;
    if (busy && (state_d == state_q)) begin
      wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
    end
    room_d  = cmd_ok ? low_idx  : room_q;
    func_d  = cmd_ok ? func_in  : func_q;
    onoff_d = cmd_ok ? onoff_in : onoff_q;
    aud_d   = cmd_ok;
    done_d  = (state_d == S_DONE) || expired;
    err_d   = cmd_bad || expired;
  end

  always_comb begin
    draw_en  = (state_q == S_DRAW);
    clear_en = (state_q == S_CLEAR);
  end

  assign cmd_room  = room_q;
  assign cmd_func  = func_q;
  assign cmd_onoff = onoff_q;
  assign aud_valid = aud_q;
  assign done      = done_q;
  assign err       = err_q;

  room_state_bank #(
    .NUM_ROOMS (NUM_ROOMS),
    .ROOM_W    (ROOM_W)
  ) u_bank (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (cmd_ok),
    .wr_room     (low_idx),
    .wr_func     (func_in),
    .wr_val      (onoff_in),
    .zero_all    (zero_all),
    .light_state (light_state),
    .door_state  (door_state)
  );

endmodule

`default_nettype wire
